// File: rtl/legv8_pkg.sv
// LEGv8 encoder shared definitions: opcodes, request classes, loader states.
// The opcode constants match the ones the main decoder compares against.
package legv8_pkg;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;

  typedef enum logic [2:0] {
    C_LDUR = 3'd0,
    C_STUR = 3'd1,
    C_CBZ  = 3'd2,
    C_ADD  = 3'd3,
    C_SUB  = 3'd4,
    C_AND  = 3'd5,
    C_ORR  = 3'd6,
    C_ILL  = 3'd7
  } instr_class_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } load_state_e;

  // True when a 19-bit signed value fits DT_address, i.e. [-256,255].
  function automatic logic fits_dt9(input logic [18:0] imm);
    return (imm[18:8] == '0) || (imm[18:8] == '1);
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Request handshake into the instruction encoder/loader.
// The master offers one instruction per cycle; the slave returns ready.
interface instr_encoder_loader_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_class;
  logic [4:0]  req_rd;
  logic [4:0]  req_rn;
  logic [4:0]  req_rm;
  logic [18:0] req_imm;
  logic        req_last;

  modport master (
    output req_valid, req_class, req_rd,
    output req_rn, req_rm, req_imm, req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_class, req_rd,
    input  req_rn, req_rm, req_imm, req_last,
    output req_ready
  );
endinterface

// File: rtl/legv8_field_packer.sv
// Combinational packer: instruction class plus fields to a LEGv8 word.
// Flags unknown classes and DT immediates that do not fit 9 bits.
module legv8_field_packer
  import legv8_pkg::*;
(
  input  instr_class_e cls,
  input  logic [4:0]   rd,
  input  logic [4:0]   rn,
  input  logic [4:0]   rm,
  input  logic [18:0]  imm,
  output logic [31:0]  word,
  output logic         illegal,
  output logic         range_err
);

  always_comb begin
    word      = '0;
    illegal   = 1'b0;
    range_err = 1'b0;
    unique case (cls)
      C_LDUR: begin
        word      = {OP_LDUR, imm[8:0], 2'b00, rn, rd};
        range_err = !fits_dt9(imm);
      end
      C_STUR: begin
        word      = {OP_STUR, imm[8:0], 2'b00, rn, rd};
        range_err = !fits_dt9(imm);
      end
      C_CBZ: word = {OP_CBZ, imm, rd};
      C_ADD: word = {OP_ADD, rm, 6'b0, rn, rd};
      C_SUB: word = {OP_SUB, rm, 6'b0, rn, rd};
      C_AND: word = {OP_AND, rm, 6'b0, rn, rd};
      C_ORR: word = {OP_ORR, rm, 6'b0, rn, rd};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Session loader: encodes requests and writes them to consecutive imem
// slots through a one-cycle output register stage.
module instr_encoder_loader
  import legv8_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  instr_encoder_loader_if.slave  req,
  output logic                   imem_we,
  output logic [AW-1:0]          imem_addr,
  output logic [31:0]            imem_wdata,
  output logic [AW:0]            count,
  output logic                   done,
  output logic                   err
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  load_state_e state, state_n;
  logic [AW:0]    count_n, base;
  logic           err_n, we_n;
  logic [AW-1:0]  addr_n;
  logic [31:0]    wdata_n;
  logic [31:0]    word;
  logic           illegal, range_err;
  logic           accept;

  legv8_field_packer u_packer (
    .cls       (instr_class_e'(req.req_class)),
    .rd        (req.req_rd),
    .rn        (req.req_rn),
    .rm        (req.req_rm),
    .imm       (req.req_imm),
    .word      (word),
    .illegal   (illegal),
    .range_err (range_err)
  );

  assign req.req_ready = (state == S_LOAD) && (count < DEPTH_C);
  assign accept        = req.req_valid && req.req_ready;
  assign done          = (state == S_DONE);

  always_comb begin
    state_n = state;
    count_n = count;
    err_n   = err;
    we_n    = 1'b0;
    addr_n  = imem_addr;
    wdata_n = imem_wdata;
    // A start that coincides with an accept lands that word at slot 0.
    base    = start ? '0 : count;
    if (start) begin
      state_n = S_LOAD;
      count_n = '0;
      err_n   = 1'b0;
    end
    if (accept) begin
      if (illegal) begin
        err_n = 1'b1;
      end else begin
        we_n    = 1'b1;
        addr_n  = base[AW-1:0];
        wdata_n = word;
        count_n = base + ONE_C;
        if (range_err) err_n = 1'b1;
      end
      if (req.req_last) state_n = S_DONE;
    end
    if (state_n == S_LOAD && count_n == DEPTH_C)
      state_n = S_DONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      count      <= '0;
      err        <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      err        <= err_n;
      imem_we    <= we_n;
      imem_addr  <= addr_n;
      imem_wdata <= wdata_n;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: single-request vector table
// plus hand sequences for back-to-back, illegal, full and reset cases.
module tb_instr_encoder_loader;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          done;
  logic          err;

  instr_encoder_loader_if rif ();

  instr_encoder_loader #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .req        (rif),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] c, input logic [4:0] rd,
                       input logic [4:0] rn, input logic [4:0] rm,
                       input logic [18:0] imm, input logic last);
    rif.req_valid = 1'b1;
    rif.req_class = c;
    rif.req_rd    = rd;
    rif.req_rn    = rn;
    rif.req_rm    = rm;
    rif.req_imm   = imm;
    rif.req_last  = last;
  endtask

  task automatic idle_req();
    rif.req_valid = 1'b0;
    rif.req_last  = 1'b0;
  endtask

  task automatic begin_session();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [18:0] imm;
    logic [31:0] word;
    logic        err;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{3'd0, 5'd1,  5'd2,  5'd0,  19'd8,       32'hF8408041, 1'b0};
    vt[1] = '{3'd1, 5'd3,  5'd4,  5'd0,  19'h7FF00,   32'hF8100083, 1'b0};
    vt[2] = '{3'd0, 5'd0,  5'd0,  5'd0,  19'd256,     32'hF8500000, 1'b1};
    vt[3] = '{3'd3, 5'd3,  5'd1,  5'd2,  19'd0,       32'h8B020023, 1'b0};
    vt[4] = '{3'd5, 5'd5,  5'd6,  5'd7,  19'd0,       32'h8A0700C5, 1'b0};
    vt[5] = '{3'd6, 5'd31, 5'd31, 5'd31, 19'd0,       32'hAA1F03FF, 1'b0};
    vt[6] = '{3'd2, 5'd5,  5'd0,  5'd0,  19'h7FFFE,   32'hB4FFFFC5, 1'b0};
    vt[7] = '{3'd2, 5'd0,  5'd0,  5'd0,  19'h3FFFF,   32'hB47FFFE0, 1'b0};
    vt[8] = '{3'd1, 5'd1,  5'd1,  5'd0,  19'd255,     32'hF80FF021, 1'b0};
    vt[9] = '{3'd0, 5'd0,  5'd0,  5'd0,  19'h7FEFF,   32'hF84FF000, 1'b1};

    idle_req();
    rif.req_class = '0;
    rif.req_rd = '0;
    rif.req_rn = '0;
    rif.req_rm = '0;
    rif.req_imm = '0;
    tick();
    tick();
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(rif.req_ready), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_ready", 32'(rif.req_ready), 32'd0);

    for (int i = 0; i < 10; i++) begin
      begin_session();
      chk($sformatf("v%0d_ready", i), 32'(rif.req_ready), 32'd1);
      drive(vt[i].cls, vt[i].rd, vt[i].rn, vt[i].rm, vt[i].imm, 1'b1);
      tick();
      idle_req();
      chk($sformatf("v%0d_we", i), 32'(imem_we), 32'd1);
      chk($sformatf("v%0d_addr", i), 32'(imem_addr), 32'd0);
      chk($sformatf("v%0d_word", i), imem_wdata, vt[i].word);
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vt[i].err));
      chk($sformatf("v%0d_done", i), 32'(done), 32'd1);
      chk($sformatf("v%0d_count", i), 32'(count), 32'd1);
      tick();
      chk($sformatf("v%0d_we_off", i), 32'(imem_we), 32'd0);
    end

    // back-to-back accepts keep the write strobe high
    begin_session();
    drive(3'd3, 5'd3, 5'd1, 5'd2, 19'd0, 1'b0);
    tick();
    chk("b2b_we0", 32'(imem_we), 32'd1);
    chk("b2b_addr0", 32'(imem_addr), 32'd0);
    chk("b2b_word0", imem_wdata, 32'h8B020023);
    drive(3'd4, 5'd4, 5'd3, 5'd1, 19'd0, 1'b1);
    tick();
    idle_req();
    chk("b2b_we1", 32'(imem_we), 32'd1);
    chk("b2b_addr1", 32'(imem_addr), 32'd1);
    chk("b2b_word1", imem_wdata, 32'hCB010064);
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_count", 32'(count), 32'd2);
    tick();
    chk("b2b_we_off", 32'(imem_we), 32'd0);

    // illegal class between two ADDs leaves no address gap
    begin_session();
    drive(3'd3, 5'd3, 5'd1, 5'd2, 19'd0, 1'b0);
    tick();
    drive(3'd7, 5'd9, 5'd9, 5'd9, 19'd0, 1'b0);
    tick();
    chk("ill_we", 32'(imem_we), 32'd0);
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_count", 32'(count), 32'd1);
    chk("ill_done", 32'(done), 32'd0);
    drive(3'd3, 5'd4, 5'd1, 5'd2, 19'd0, 1'b1);
    tick();
    idle_req();
    chk("ill_we2", 32'(imem_we), 32'd1);
    chk("ill_addr2", 32'(imem_addr), 32'd1);
    chk("ill_word2", imem_wdata, 32'h8B020024);
    chk("ill_count2", 32'(count), 32'd2);
    chk("ill_err_sticky", 32'(err), 32'd1);

    // start clears err; an illegal last still ends the session
    begin_session();
    chk("restart_err", 32'(err), 32'd0);
    chk("restart_count", 32'(count), 32'd0);
    chk("restart_done", 32'(done), 32'd0);
    drive(3'd7, 5'd0, 5'd0, 5'd0, 19'd0, 1'b1);
    tick();
    idle_req();
    chk("illast_done", 32'(done), 32'd1);
    chk("illast_err", 32'(err), 32'd1);
    chk("illast_we", 32'(imem_we), 32'd0);
    chk("illast_count", 32'(count), 32'd0);

    // filling all DEPTH slots ends the session without req_last
    begin_session();
    drive(3'd6, 5'd1, 5'd2, 5'd3, 19'd0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("full_ready%0d", i), 32'(rif.req_ready), 32'd1);
      tick();
      chk($sformatf("full_we%0d", i), 32'(imem_we), 32'd1);
      chk($sformatf("full_addr%0d", i), 32'(imem_addr), 32'(i));
    end
    chk("full_ready_off", 32'(rif.req_ready), 32'd0);
    chk("full_done", 32'(done), 32'd1);
    chk("full_count", 32'(count), 32'(DEPTH));
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("full_nowr%0d", i), 32'(imem_we), 32'd0);
      chk($sformatf("full_cnt_hold%0d", i), 32'(count), 32'(DEPTH));
    end
    idle_req();

    // restart mid-session returns to slot 0
    begin_session();
    drive(3'd3, 5'd1, 5'd1, 5'd1, 19'd0, 1'b0);
    tick();
    idle_req();
    start = 1'b1;
    chk("mid_inflight_we", 32'(imem_we), 32'd1);
    tick();
    start = 1'b0;
    chk("mid_count", 32'(count), 32'd0);
    drive(3'd4, 5'd2, 5'd2, 5'd2, 19'd0, 1'b1);
    tick();
    idle_req();
    chk("mid_addr", 32'(imem_addr), 32'd0);
    chk("mid_word", imem_wdata, 32'hCB020042);

    // reset during a write cycle drops it at once
    begin_session();
    drive(3'd3, 5'd3, 5'd1, 5'd2, 19'd0, 1'b0);
    tick();
    chk("rw_we_pre", 32'(imem_we), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rw_we", 32'(imem_we), 32'd0);
    chk("rw_count", 32'(count), 32'd0);
    chk("rw_ready", 32'(rif.req_ready), 32'd0);
    chk("rw_done", 32'(done), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rw_idle_ready", 32'(rif.req_ready), 32'd0);
    chk("rw_idle_we", 32'(imem_we), 32'd0);
    idle_req();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
